// File: rtl/cylon_scanner.sv
// Cylon scanner: drives a one-hot "eye" across NUMBER_DEVICES positions at a
// programmable step rate. It either bounces end to end, with an optional dwell
// at each end, or wraps upward from N-1 to 0.
// Ports:
//   clk, rst    - system clock; synchronous active-high reset
//   enable      - 1 = scanning, 0 = idle with the output blanked
//   step_clks   - clk cycles per step (0 behaves as 1)
//   wrap_mode   - 0 = bounce, 1 = wrap N-1 -> 0, always moving upward
//   active      - one-hot of position while scanning, all zero when idle
//   position    - current device index
//   moving_up   - current direction, 1 = increasing index
//   step_pulse  - one-cycle strobe on each step event
module cylon_scanner #(
    parameter int unsigned NUMBER_DEVICES  = 16,
    parameter int unsigned END_PAUSE_STEPS = 2,
    parameter int unsigned POS_W           = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [29:0]               step_clks,
    input  logic                      wrap_mode,
    output logic [NUMBER_DEVICES-1:0] active,
    output logic [POS_W-1:0]          position,
    output logic                      moving_up,
    output logic                      step_pulse
);

    localparam int unsigned STEP_W  = 30;
    localparam int unsigned PAUSE_W = (END_PAUSE_STEPS > 0) ? $clog2(END_PAUSE_STEPS + 1) : 1;
    localparam logic [POS_W-1:0]   LAST_POS   = POS_W'(NUMBER_DEVICES - 1);
    localparam logic [PAUSE_W-1:0] PAUSE_INIT = PAUSE_W'(END_PAUSE_STEPS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic [STEP_W-1:0]         timer_q, timer_d;
    logic [PAUSE_W-1:0]        pause_cnt_q, pause_cnt_d;
    logic [POS_W-1:0]          position_q, position_d;
    logic                      moving_up_q, moving_up_d;
    logic [NUMBER_DEVICES-1:0] active_q, active_d;
    logic                      step_pulse_q, step_pulse_d;

    logic [STEP_W-1:0]         step_max_c;
    logic                      term_c;
    logic                      at_end_c;

    // One position step in the given direction. The wrap-around arms also keep
    // the index inside 0..N-1 when N is not a power of two.
    function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] pos,
                                                  input logic             up);
        if (up) begin
            step_pos = (pos == LAST_POS) ? '0 : pos + POS_W'(1);
        end else begin
            step_pos = (pos == '0) ? LAST_POS : pos - POS_W'(1);
        end
    endfunction

    // Terminal count uses >= so that lowering step_clks below the running count
    // fires on the very next cycle instead of waiting for the timer to wrap.
    always_comb begin
        step_max_c = (step_clks == '0) ? STEP_W'(1) : step_clks;
        term_c     = (state_q != ST_IDLE) && (timer_q >= (step_max_c - STEP_W'(1)));
        at_end_c   = moving_up_q ? (position_q == LAST_POS) : (position_q == '0);
    end

    // Next-state, position and output logic.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        pause_cnt_d  = pause_cnt_q;
        position_d   = position_q;
        moving_up_d  = moving_up_q;
        step_pulse_d = 1'b0;
        active_d     = '0;

        unique case (state_q)
            ST_IDLE: begin
                timer_d     = '0;
                pause_cnt_d = '0;
                if (enable) begin
                    state_d = ST_SCAN;
                end
            end

            ST_SCAN: begin
                if (!enable) begin
                    // A step landing on the same cycle as enable falling is dropped.
                    state_d     = ST_IDLE;
                    timer_d     = '0;
                    pause_cnt_d = '0;
                end else begin
                    timer_d = term_c ? '0 : timer_q + STEP_W'(1);
                    if (term_c) begin
                        step_pulse_d = 1'b1;
                        if (wrap_mode) begin
                            moving_up_d = 1'b1;
                            position_d  = step_pos(position_q, 1'b1);
                        end else if (!at_end_c) begin
                            position_d = step_pos(position_q, moving_up_q);
                        end else if (NUMBER_DEVICES > 1) begin
                            // Bounce: reverse, then dwell or move straight back.
                            moving_up_d = !moving_up_q;
                            if (END_PAUSE_STEPS > 0) begin
                                state_d     = ST_PAUSE;
                                pause_cnt_d = PAUSE_INIT;
                            end else begin
                                position_d = step_pos(position_q, !moving_up_q);
                            end
                        end
                    end
                end
            end

            ST_PAUSE: begin
                if (!enable) begin
                    state_d     = ST_IDLE;
                    timer_d     = '0;
                    pause_cnt_d = '0;
                end else begin
                    timer_d = term_c ? '0 : timer_q + STEP_W'(1);
                    if (term_c) begin
                        step_pulse_d = 1'b1;
                        if (wrap_mode) begin
                            state_d     = ST_SCAN;
                            pause_cnt_d = '0;
                            moving_up_d = 1'b1;
                            position_d  = step_pos(position_q, 1'b1);
                        end else if (pause_cnt_q == PAUSE_W'(1)) begin
                            // Direction was already reversed on entry to the dwell.
                            state_d     = ST_SCAN;
                            pause_cnt_d = '0;
                            position_d  = step_pos(position_q, moving_up_q);
                        end else begin
                            pause_cnt_d = pause_cnt_q - PAUSE_W'(1);
                        end
                    end
                end
            end

            default: begin
                state_d     = ST_IDLE;
                timer_d     = '0;
                pause_cnt_d = '0;
            end
        endcase

        // The one-hot is registered together with the position it encodes.
        if (state_d != ST_IDLE) begin
            active_d = NUMBER_DEVICES'(1) << position_d;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            pause_cnt_q  <= '0;
            position_q   <= '0;
            moving_up_q  <= 1'b1;
            active_q     <= '0;
            step_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            pause_cnt_q  <= pause_cnt_d;
            position_q   <= position_d;
            moving_up_q  <= moving_up_d;
            active_q     <= active_d;
            step_pulse_q <= step_pulse_d;
        end
    end

    assign active     = active_q;
    assign position   = position_q;
    assign moving_up  = moving_up_q;
    assign step_pulse = step_pulse_q;

endmodule

// File: tb/tb_cylon_scanner.sv
// Directed bench for cylon_scanner with default parameters (N=16, dwell 2 steps).
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
module tb_cylon_scanner;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [29:0] step_clks;
    logic        wrap_mode;
    logic [15:0] active;
    logic [3:0]  position;
    logic        moving_up;
    logic        step_pulse;

    int checks = 0;
    int errors = 0;

    int exp_pos [36];
    int exp_up  [36];

    cylon_scanner #(
        .NUMBER_DEVICES (16),
        .END_PAUSE_STEPS(2),
        .POS_W          (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .step_clks (step_clks),
        .wrap_mode (wrap_mode),
        .active    (active),
        .position  (position),
        .moving_up (moving_up),
        .step_pulse(step_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int pos, input int up, input int pulse,
                           input logic [15:0] act);
        chk({tag, ".position"}, 32'(position), 32'(pos));
        chk({tag, ".moving_up"}, 32'(moving_up), 32'(up));
        chk({tag, ".step_pulse"}, 32'(step_pulse), 32'(pulse));
        chk({tag, ".active"}, 32'(active), 32'(act));
    endtask

    initial begin
        // Expected bounce trajectory, one entry per step period.
        for (int k = 0; k < 16; k++) begin exp_pos[k] = k; exp_up[k] = 1; end
        exp_pos[16] = 15; exp_up[16] = 0;
        exp_pos[17] = 15; exp_up[17] = 0;
        for (int k = 18; k <= 32; k++) begin exp_pos[k] = 32 - k; exp_up[k] = 0; end
        exp_pos[33] = 0; exp_up[33] = 1;
        exp_pos[34] = 0; exp_up[34] = 1;
        exp_pos[35] = 1; exp_up[35] = 1;

        // T1: reset wins over active inputs
        rst = 1'b1; enable = 1'b1; wrap_mode = 1'b1; step_clks = 30'd5;
        tick(); tick(); tick();
        chk_all("t1_reset", 0, 1, 0, 16'h0000);

        // T2: bounce, 4 clks per step, 2-step dwell at each end
        wrap_mode = 1'b0; step_clks = 30'd4; rst = 1'b0;
        tick();
        for (int c = 0; c < 36 * 4; c++) begin
            chk_all($sformatf("t2_c%0d", c), exp_pos[c / 4], exp_up[c / 4],
                    ((c % 4 == 0) && (c != 0)) ? 1 : 0, 16'(16'h1 << exp_pos[c / 4]));
            tick();
        end

        // T3: wrap, one step per clk
        rst = 1'b1; tick();
        rst = 1'b0; enable = 1'b1; wrap_mode = 1'b1; step_clks = 30'd1;
        tick();
        for (int c = 0; c < 18; c++) begin
            chk_all($sformatf("t3_c%0d", c), c % 16, 1, (c != 0) ? 1 : 0,
                    16'(16'h1 << (c % 16)));
            chk($sformatf("t3_onehot_c%0d", c), 32'($countones(active)), 32'd1);
            tick();
        end

        // T4: enable drop at position 7, resume, then drop coinciding with a step
        rst = 1'b1; tick();
        rst = 1'b0; enable = 1'b1; wrap_mode = 1'b0; step_clks = 30'd2;
        tick();
        repeat (14) tick();
        chk_all("t4_at7", 7, 1, 1, 16'h0080);
        enable = 1'b0; tick();
        chk_all("t4_off", 7, 1, 0, 16'h0000);
        tick(); tick();
        chk_all("t4_off_hold", 7, 1, 0, 16'h0000);
        enable = 1'b1; tick();
        chk_all("t4_resume", 7, 1, 0, 16'h0080);
        tick();
        chk_all("t4_resume_mid", 7, 1, 0, 16'h0080);
        tick();
        chk_all("t4_step8", 8, 1, 1, 16'h0100);
        tick();
        enable = 1'b0; tick();
        chk_all("t4_step_discard", 8, 1, 0, 16'h0000);

        // T5: step_clks=0 behaves as 1; shrink step_clks mid-count
        rst = 1'b1; tick();
        rst = 1'b0; enable = 1'b1; wrap_mode = 1'b1; step_clks = 30'd0;
        tick();
        chk_all("t5_c0", 0, 1, 0, 16'h0001);
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk_all($sformatf("t5_c%0d", c), c, 1, 1, 16'(16'h1 << c));
        end
        enable = 1'b0; tick();
        chk_all("t5_idle", 4, 1, 0, 16'h0000);
        step_clks = 30'd100; enable = 1'b1; tick();
        chk_all("t5_rescan", 4, 1, 0, 16'h0010);
        repeat (50) tick();
        chk_all("t5_timer50", 4, 1, 0, 16'h0010);
        step_clks = 30'd3; tick();
        chk_all("t5_shrink_fire", 5, 1, 1, 16'h0020);
        tick();
        chk_all("t5_p1", 5, 1, 0, 16'h0020);
        tick();
        chk_all("t5_p2", 5, 1, 0, 16'h0020);
        tick();
        chk_all("t5_p3", 6, 1, 1, 16'h0040);

        // T6: reset while dwelling at position 15
        rst = 1'b1; tick();
        rst = 1'b0; enable = 1'b1; wrap_mode = 1'b0; step_clks = 30'd1;
        tick();
        repeat (15) tick();
        chk_all("t6_at15", 15, 1, 1, 16'h8000);
        tick();
        chk_all("t6_pause", 15, 0, 1, 16'h8000);
        rst = 1'b1; tick();
        chk_all("t6_reset", 0, 1, 0, 16'h0000);
        tick();
        chk_all("t6_reset_hold", 0, 1, 0, 16'h0000);
        rst = 1'b0; tick();
        chk_all("t6_restart", 0, 1, 0, 16'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
